// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM state
// encoding, datapath width and the status codes for the overflow path.
package multdiv_ctrl_pkg;

    localparam int MD_XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_e;

    localparam logic [MD_XLEN-1:0] RSTATUS_MULT = 32'd4;
    localparam logic [MD_XLEN-1:0] RSTATUS_DIV  = 32'd5;

    function automatic logic [MD_XLEN-1:0] md_status(input logic is_mult);
        return is_mult ? RSTATUS_MULT : RSTATUS_DIV;
    endfunction

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Handshake bundle between the sequencer (master) and the multi-cycle
// multiply/divide unit (slave).
//   md_ctrl_mult/md_ctrl_div : start pulses, master -> unit
//   md_a/md_b                : held operands, master -> unit
//   md_result/md_exception   : result and exception flag, unit -> master
//   md_ready                 : single-cycle result-valid pulse, unit -> master
interface multdiv_if;
    import multdiv_ctrl_pkg::*;

    logic               md_ctrl_mult;
    logic               md_ctrl_div;
    logic [MD_XLEN-1:0] md_a;
    logic [MD_XLEN-1:0] md_b;
    logic [MD_XLEN-1:0] md_result;
    logic               md_exception;
    logic               md_ready;

    modport master (
        output md_ctrl_mult,
        output md_ctrl_div,
        output md_a,
        output md_b,
        input  md_result,
        input  md_exception,
        input  md_ready
    );

    modport slave (
        input  md_ctrl_mult,
        input  md_ctrl_div,
        input  md_a,
        input  md_b,
        output md_result,
        output md_exception,
        output md_ready
    );

endinterface

// File: rtl/multdiv_ctrl_md_cycle_counter.sv
// WAIT-cycle counter for the multdiv watchdog.
//   clk, reset_n : clock, synchronous active-low reset
//   clr          : zero the count (wins over en)
//   en           : count this cycle
//   tc           : this counted cycle brings the count up to LIMIT
module md_cycle_counter #(
    parameter int CNT_W = 6,
    parameter int LIMIT = 40
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // The count holds completed WAIT cycles, so the LIMIT-th WAIT cycle
    // is the one that sees LIMIT-1.
    assign tc = en & (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multdiv_ctrl.sv
// Multiply/divide sequencer: detects a mult/div in execute, pulses the
// unit with held operands, stalls the front end until md_ready, then
// steers the registered result and status word into X/M for one cycle.
// Optional: MULTDIV_WATCHDOG_EN aborts a WAIT after LATENCY_MAX cycles.
// Ports:
//   clk, reset_n                 : clock, synchronous active-low reset
//   x_valid, x_is_mult, x_is_div : execute-stage instruction info
//   x_a, x_b                     : bypassed execute operands
//   md                           : multdiv unit handshake (master)
//   stall                        : freeze PC, F/D, D/X; nop into X/M
//   res_sel, res_data, res_ovf   : X/M result select, data, status
//   busy                         : sequencer not idle
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int LATENCY_MAX = 40,
    parameter int CNT_W       = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               x_valid,
    input  logic               x_is_mult,
    input  logic               x_is_div,
    input  logic [MD_XLEN-1:0] x_a,
    input  logic [MD_XLEN-1:0] x_b,
    multdiv_if.master          md,
    output logic               stall,
    output logic               res_sel,
    output logic [MD_XLEN-1:0] res_data,
    output logic [MD_XLEN-1:0] res_ovf,
    output logic               busy
);

    if (LATENCY_MAX < 1 || LATENCY_MAX >= (1 << CNT_W)) begin : g_bad_cfg
        $error("multdiv_ctrl: CNT_W too narrow for LATENCY_MAX");
    end

    md_state_e          state_q, state_d;
    logic               op_mult_q, op_mult_d;
    logic [MD_XLEN-1:0] md_a_q, md_a_d;
    logic [MD_XLEN-1:0] md_b_q, md_b_d;
    logic [MD_XLEN-1:0] res_data_q, res_data_d;
    logic [MD_XLEN-1:0] res_ovf_q, res_ovf_d;
    logic               start;

    assign start = x_valid & (x_is_mult | x_is_div);

`ifdef MULTDIV_WATCHDOG_EN
    logic cnt_clr;
    logic cnt_en;
    logic cnt_tc;

    md_cycle_counter #(
        .CNT_W (CNT_W),
        .LIMIT (LATENCY_MAX)
    ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .tc      (cnt_tc)
    );
`endif

    always_comb begin
        state_d         = state_q;
        op_mult_d       = op_mult_q;
        md_a_d          = md_a_q;
        md_b_d          = md_b_q;
        res_data_d      = res_data_q;
        res_ovf_d       = res_ovf_q;
        stall           = 1'b0;
        res_sel         = 1'b0;
        md.md_ctrl_mult = 1'b0;
        md.md_ctrl_div  = 1'b0;
`ifdef MULTDIV_WATCHDOG_EN
        cnt_clr         = 1'b0;
        cnt_en          = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // Stall in the detect cycle so D/X holds the op.
                if (start) begin
                    stall     = 1'b1;
                    md_a_d    = x_a;
                    md_b_d    = x_b;
                    op_mult_d = x_is_mult;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                stall           = 1'b1;
                md.md_ctrl_mult = op_mult_q;
                md.md_ctrl_div  = ~op_mult_q;
`ifdef MULTDIV_WATCHDOG_EN
                cnt_clr         = 1'b1;
`endif
                state_d         = ST_WAIT;
            end
            ST_WAIT: begin
                stall = 1'b1;
`ifdef MULTDIV_WATCHDOG_EN
                cnt_en = 1'b1;
`endif
                // A ready that coincides with the limit still completes.
                if (md.md_ready) begin
                    res_data_d = md.md_result;
                    res_ovf_d  = md.md_exception ? md_status(op_mult_q)
                                                 : '0;
                    state_d    = ST_DONE;
                end
`ifdef MULTDIV_WATCHDOG_EN
                else if (cnt_tc) begin
                    res_data_d = '0;
                    res_ovf_d  = md_status(op_mult_q);
                    state_d    = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                // The op leaves D/X this edge; start is not looked at.
                res_sel = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            op_mult_q  <= 1'b0;
            md_a_q     <= '0;
            md_b_q     <= '0;
            res_data_q <= '0;
            res_ovf_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_mult_q  <= op_mult_d;
            md_a_q     <= md_a_d;
            md_b_q     <= md_b_d;
            res_data_q <= res_data_d;
            res_ovf_q  <= res_ovf_d;
        end
    end

    assign md.md_a   = md_a_q;
    assign md.md_b   = md_b_q;
    assign res_data  = res_data_q;
    assign res_ovf   = res_ovf_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Randomized bench for multdiv_ctrl; the bench plays the multdiv unit
// and predicts results, status and stall timing per operation.
module tb_multdiv_ctrl;

    localparam int LAT = 8;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        x_valid   = 1'b0;
    logic        x_is_mult = 1'b0;
    logic        x_is_div  = 1'b0;
    logic [31:0] x_a       = '0;
    logic [31:0] x_b       = '0;
    logic        stall;
    logic        res_sel;
    logic        busy;
    logic [31:0] res_data;
    logic [31:0] res_ovf;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_data = '0;
    logic [31:0] exp_ovf  = '0;

    multdiv_if md_bus();

    multdiv_ctrl #(
        .LATENCY_MAX (LAT),
        .CNT_W       (6)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .x_valid   (x_valid),
        .x_is_mult (x_is_mult),
        .x_is_div  (x_is_div),
        .x_a       (x_a),
        .x_b       (x_b),
        .md        (md_bus),
        .stall     (stall),
        .res_sel   (res_sel),
        .res_data  (res_data),
        .res_ovf   (res_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // What the multdiv unit itself would return for an op.
    function automatic void unit_model(input bit mul,
                                       input logic [31:0] a,
                                       input logic [31:0] b,
                                       output logic [31:0] r,
                                       output bit e);
        longint p;
        if (mul) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p != longint'($signed(r)));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
            r = a;
            e = 1'b1;
        end else begin
            r = $signed(a) / $signed(b);
            e = 1'b0;
        end
    endfunction

    // Entered and left at posedge+1.
    task automatic idle_cycle();
        x_valid = 1'($urandom_range(0, 1));
        if (x_valid) begin
            x_is_mult = 1'b0;
            x_is_div  = 1'b0;
        end else begin
            x_is_mult = 1'($urandom);
            x_is_div  = 1'($urandom);
        end
        x_a = $urandom;
        x_b = $urandom;
        md_bus.md_ready     = 1'($urandom);
        md_bus.md_result    = $urandom;
        md_bus.md_exception = 1'($urandom);
        @(negedge clk);
        chk("idle_stall", stall, 0);
        chk("idle_busy", busy, 0);
        chk("idle_res_sel", res_sel, 0);
        chk("idle_pulse", md_bus.md_ctrl_mult | md_bus.md_ctrl_div, 0);
        chk("idle_res_data", res_data, exp_data);
        chk("idle_res_ovf", res_ovf, exp_ovf);
        @(posedge clk);
        #1;
    endtask

    // One op held in execute from detection through DONE.
    task automatic run_op(input bit mul, input bit dv,
                          input logic [31:0] a, input logic [31:0] b,
                          input int k, input bit stray,
                          input bit timeout);
        bit          op_m;
        logic [31:0] r;
        bit          e;
        int          total;
        int          n_stall = 0;
        int          n_pulse = 0;
        int          n_sel   = 0;
        int          pulse_c = -1;
        bit          pulse_m = 1'b0;
        bit          rdy;
        op_m = mul;
        unit_model(op_m, a, b, r, e);
        if (timeout) begin
            total    = LAT + 2;
            exp_data = 32'd0;
            exp_ovf  = op_m ? 32'd4 : 32'd5;
        end else begin
            total    = k + 2;
            exp_data = r;
            exp_ovf  = e ? (op_m ? 32'd4 : 32'd5) : 32'd0;
        end
        x_valid   = 1'b1;
        x_is_mult = mul;
        x_is_div  = dv;
        x_a       = a;
        x_b       = b;
        for (int c = 0; c <= total; c++) begin
            rdy = !timeout && (c == k + 1);
            md_bus.md_ready     = rdy || (stray && c == 1);
            md_bus.md_result    = rdy ? r : $urandom;
            md_bus.md_exception = rdy ? e : 1'($urandom);
            @(negedge clk);
            if (stall) n_stall++;
            if (res_sel) n_sel++;
            if (md_bus.md_ctrl_mult || md_bus.md_ctrl_div) begin
                n_pulse++;
                pulse_c = c;
                pulse_m = md_bus.md_ctrl_mult;
            end
            if (c == 0) chk("start_busy", busy, 0);
            if (c == 1) begin
                chk("issue_md_a", md_bus.md_a, a);
                chk("issue_md_b", md_bus.md_b, b);
            end
            if (c == total) begin
                chk("done_res_sel", res_sel, 1);
                chk("done_stall", stall, 0);
                chk("done_busy", busy, 1);
                chk("done_res_data", res_data, exp_data);
                chk("done_res_ovf", res_ovf, exp_ovf);
                chk("done_md_a", md_bus.md_a, a);
                chk("done_md_b", md_bus.md_b, b);
            end
            @(posedge clk);
            #1;
        end
        chk("stall_cycles", n_stall, total);
        chk("pulse_count", n_pulse, 1);
        chk("pulse_cycle", pulse_c, 1);
        chk("pulse_is_mult", pulse_m, op_m);
        chk("sel_cycles", n_sel, 1);
    endtask

    initial begin
        int opc;
        md_bus.md_ready     = 1'b0;
        md_bus.md_result    = '0;
        md_bus.md_exception = 1'b0;

        reset_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_sel", res_sel, 0);
        chk("rst_pulse", md_bus.md_ctrl_mult | md_bus.md_ctrl_div, 0);
        chk("rst_md_a", md_bus.md_a, 0);
        chk("rst_md_b", md_bus.md_b, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_ovf", res_ovf, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle_cycle();

        run_op(1'b1, 1'b0, 32'd6, 32'd7, 3, 1'b0, 1'b0);
        idle_cycle();
        run_op(1'b0, 1'b1, 32'd10, 32'd0, 4, 1'b0, 1'b0);
        idle_cycle();
        run_op(1'b1, 1'b1, 32'h0001_0000, 32'h0001_0000, 2, 1'b0, 1'b0);
        run_op(1'b1, 1'b0, 32'd100, 32'hffff_fffd, 1, 1'b1, 1'b0);
        run_op(1'b1, 1'b0, 32'h7fff_ffff, 32'd2, 5, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            opc = $urandom_range(0, 2);
            run_op(opc != 1, opc != 0,
                   ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9))
                                               : $urandom,
                   ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2))
                                               : $urandom,
                   $urandom_range(1, LAT), 1'($urandom), 1'b0);
            for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
        end

        // Abandon an op mid-WAIT, then offer a stray ready.
        x_valid   = 1'b1;
        x_is_mult = 1'b0;
        x_is_div  = 1'b1;
        x_a       = 32'd77;
        x_b       = 32'd7;
        md_bus.md_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        x_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        md_bus.md_ready     = 1'b1;
        md_bus.md_result    = 32'd11;
        md_bus.md_exception = 1'b1;
        exp_data = 32'd0;
        exp_ovf  = 32'd0;
        @(negedge clk);
        chk("midrst_stall", stall, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_res_sel", res_sel, 0);
        chk("midrst_md_a", md_bus.md_a, 0);
        chk("midrst_md_b", md_bus.md_b, 0);
        chk("midrst_res_data", res_data, 0);
        chk("midrst_res_ovf", res_ovf, 0);
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) idle_cycle();

`ifdef MULTDIV_WATCHDOG_EN
        run_op(1'b1, 1'b0, 32'd3, 32'd4, 0, 1'b0, 1'b1);
        run_op(1'b0, 1'b1, 32'd9, 32'd3, LAT, 1'b0, 1'b0);
        run_op(1'b0, 1'b1, 32'd9, 32'd3, 0, 1'b0, 1'b1);
        idle_cycle();
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
